// File: rtl/c4_move_sequencer.sv
// ---------------------------------------------------------------------------
// c4_move_sequencer
//
// Sequences the Connect-4 board memory for one piece drop. A request names a
// column; the sequencer scans that column bottom-up with timed read pulses
// until it finds an empty cell. It then writes the current player's piece
// there and reports the outcome to the game FSM with a one-cycle pulse.
//
// Ports
//   i_clk          clock
//   i_reset        synchronous, active-high reset (aborts any move in flight)
//   i_move_valid   drop request, accepted in IDLE only
//   i_move_col     requested column
//   o_move_ready   high only while IDLE
//   i_new_game     resets the turn to player 0, honoured in IDLE only
//   i_rd_cells     read row from memory; column c at bits [2c+1:2c]
//                  (00 empty, 01 player 0, 10 player 1, 11 treated as occupied)
//   o_rdaddr       memory read address (held through setup, read and wait)
//   o_ren          one-cycle memory read strobe
//   o_waddr        memory write address
//   o_wen          one-cycle memory write strobe
//   o_colval       column for the write
//   o_player       player for the write (1 writes 10, 0 writes 01)
//   o_cur_player   whose turn it is
//   o_move_done    one-cycle result pulse
//   o_move_status  00 ok, 01 column full, 10 invalid column
//   o_move_row     address written (meaningful when status is 00)
// ---------------------------------------------------------------------------
module c4_move_sequencer #(
    parameter int unsigned NUM_ROWS    = 8,
    parameter int unsigned NUM_COLS    = 7,
    parameter logic [4:0]  BOTTOM_ADDR = 5'd31,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_move_valid,
    input  logic [2:0]  i_move_col,
    output logic        o_move_ready,
    input  logic        i_new_game,
    input  logic [15:0] i_rd_cells,
    output logic [4:0]  o_rdaddr,
    output logic        o_ren,
    output logic [4:0]  o_waddr,
    output logic        o_wen,
    output logic [2:0]  o_colval,
    output logic        o_player,
    output logic        o_cur_player,
    output logic        o_move_done,
    output logic [1:0]  o_move_status,
    output logic [4:0]  o_move_row
);

    // Counter widths follow the parameters; both counters count up from 0.
    localparam int unsigned ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned DLY_MAX = (SETUP_CYC > RD_LAT) ? SETUP_CYC : RD_LAT;
    localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(SETUP_CYC - 1);
    localparam logic [DLY_W-1:0] RD_LAST    = DLY_W'(RD_LAT - 1);

    localparam logic [1:0] STAT_OK   = 2'b00;
    localparam logic [1:0] STAT_FULL = 2'b01;
    localparam logic [1:0] STAT_BAD  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StRead,
        StWait,
        StCheck,
        StWsetup,
        StWrite,
        StDone
    } state_e;

    state_e           r_state;
    logic [2:0]       r_col;
    logic [4:0]       r_addr;
    logic [ROW_W-1:0] r_row_cnt;
    logic [DLY_W-1:0] r_dly_cnt;
    logic [1:0]       r_status;
    logic             r_cur_player;

    state_e           w_state_nxt;
    logic [2:0]       w_col_nxt;
    logic [4:0]       w_addr_nxt;
    logic [ROW_W-1:0] w_row_cnt_nxt;
    logic [DLY_W-1:0] w_dly_cnt_nxt;
    logic [1:0]       w_status_nxt;
    logic             w_cur_player_nxt;

    logic             w_col_bad;
    logic [1:0]       w_field;

    // NUM_COLS may be 8, in which case every 3-bit column is legal.
    assign w_col_bad = (32'(i_move_col) >= NUM_COLS);

    // Cell of the latched column within the row just read.
    assign w_field = i_rd_cells[{r_col, 1'b0} +: 2];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_col        <= 3'd0;
            r_addr       <= 5'd0;
            r_row_cnt    <= '0;
            r_dly_cnt    <= '0;
            r_status     <= STAT_OK;
            r_cur_player <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_addr       <= w_addr_nxt;
            r_row_cnt    <= w_row_cnt_nxt;
            r_dly_cnt    <= w_dly_cnt_nxt;
            r_status     <= w_status_nxt;
            r_cur_player <= w_cur_player_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_col_nxt        = r_col;
        w_addr_nxt       = r_addr;
        w_row_cnt_nxt    = r_row_cnt;
        w_dly_cnt_nxt    = r_dly_cnt;
        w_status_nxt     = r_status;
        w_cur_player_nxt = r_cur_player;

        o_move_ready  = 1'b0;
        o_rdaddr      = 5'd0;
        o_ren         = 1'b0;
        o_waddr       = 5'd0;
        o_wen         = 1'b0;
        o_colval      = 3'd0;
        o_player      = 1'b0;
        o_move_done   = 1'b0;
        o_move_status = 2'b00;
        o_move_row    = 5'd0;

        unique case (r_state)
            StIdle: begin
                o_move_ready = 1'b1;
                if (i_new_game) begin
                    w_cur_player_nxt = 1'b0;
                end
                if (i_move_valid) begin
                    w_col_nxt     = i_move_col;
                    w_addr_nxt    = BOTTOM_ADDR;
                    w_row_cnt_nxt = '0;
                    w_dly_cnt_nxt = '0;
                    if (w_col_bad) begin
                        w_status_nxt = STAT_BAD;
                        w_state_nxt  = StDone;
                    end else begin
                        w_status_nxt = STAT_OK;
                        w_state_nxt  = StSetup;
                    end
                end
            end

            StSetup: begin
                o_rdaddr = r_addr;
                if (r_dly_cnt == SETUP_LAST) begin
                    w_dly_cnt_nxt = '0;
                    w_state_nxt   = StRead;
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                end
            end

            StRead: begin
                o_rdaddr      = r_addr;
                o_ren         = 1'b1;
                w_dly_cnt_nxt = '0;
                w_state_nxt   = StWait;
            end

            StWait: begin
                o_rdaddr = r_addr;
                if (r_dly_cnt == RD_LAST) begin
                    w_dly_cnt_nxt = '0;
                    w_state_nxt   = StCheck;
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                end
            end

            StCheck: begin
                o_rdaddr = r_addr;
                if (w_field == 2'b00) begin
                    w_status_nxt = STAT_OK;
                    w_state_nxt  = StWsetup;
                end else if (r_row_cnt == LAST_ROW) begin
                    // Top row is occupied too: nothing to write.
                    w_status_nxt = STAT_FULL;
                    w_state_nxt  = StDone;
                end else begin
                    w_row_cnt_nxt = r_row_cnt + 1'b1;
                    w_addr_nxt    = r_addr - 5'd1;
                    w_state_nxt   = StSetup;
                end
            end

            StWsetup: begin
                o_waddr     = r_addr;
                o_colval    = r_col;
                o_player    = r_cur_player;
                w_state_nxt = StWrite;
            end

            StWrite: begin
                o_waddr     = r_addr;
                o_colval    = r_col;
                o_player    = r_cur_player;
                o_wen       = 1'b1;
                w_state_nxt = StDone;
            end

            StDone: begin
                o_move_done   = 1'b1;
                o_move_status = r_status;
                o_move_row    = (r_status == STAT_OK) ? r_addr : 5'd0;
                // Only a successful drop passes the turn.
                if (r_status == STAT_OK) begin
                    w_cur_player_nxt = ~r_cur_player;
                end
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_cur_player = r_cur_player;

endmodule
